// File: rtl/md_stall_ctrl.sv
// md_stall_ctrl: hazard controller for the five-stage MIPS core.
// Resolves load-use and HI/LO-vs-MDU hazards, sequences the multi-cycle
// multiply/divide unit and counts stall cycles.
//
// Ports:
//   clk, resetn    clock, synchronous active-low reset
//   IR_D, IR_E     instructions in the D and E stages
//   use_bus_D      [1] D reads rs, [0] D reads rt
//   mem_read_E     E instruction is a load writing IR_E[20:16]
//   exc_flush      exception/eret flush this cycle (overrides all stalls)
//   stall_D        freeze PC and IF/ID
//   flush_E        bubble into ID/EX (equals stall_D)
//   md_start       one-cycle MDU start strobe
//   md_is_div      with md_start: 1 = div/divu
//   md_signed      with md_start: 1 = mult/div
//   md_busy        MDU computing
//   md_done        one-cycle pulse when HI/LO are written
//   stall_cycles   free-running count of stall_D cycles
module md_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic [1:0]  use_bus_D,
  input  logic        mem_read_E,
  input  logic        exc_flush,
  output logic        stall_D,
  output logic        flush_E,
  output logic        md_start,
  output logic        md_is_div,
  output logic        md_signed,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cycles
);

  localparam logic [5:0] OpSpecial = 6'b000000;
  localparam logic [4:0] MultCnt   = 5'(MULT_CYCLES);
  localparam logic [4:0] DivCnt    = 5'(DIV_CYCLES);

  // MDU state is implied by the busy counter.
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [4:0]  cnt_q, cnt_d;
  logic        md_done_q, md_done_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [0:0]  state;

  logic        start_cls_e;
  logic        hilo_cls_d;
  logic [4:0]  rt_e;
  logic        ld_stall;
  logic        md_stall;

  // Start class: funct 0110xx; HI/LO class adds mfhi/mthi/mflo/mtlo (0100xx).
  assign start_cls_e = (IR_E[31:26] == OpSpecial) && (IR_E[5:2] == 4'b0110);
  assign hilo_cls_d  = (IR_D[31:26] == OpSpecial) &&
                       ((IR_D[5:2] == 4'b0110) || (IR_D[5:2] == 4'b0100));

  assign rt_e     = IR_E[20:16];
  assign ld_stall = mem_read_E && (rt_e != 5'd0) &&
                    ((use_bus_D[1] && (IR_D[25:21] == rt_e)) ||
                     (use_bus_D[0] && (IR_D[20:16] == rt_e)));

  assign state   = (cnt_q != 5'd0) ? StBusy : StIdle;
  assign md_busy = (state == StBusy);

  assign md_start  = resetn & start_cls_e & ~md_busy & ~exc_flush;
  assign md_is_div = md_start & IR_E[1];
  assign md_signed = md_start & ~IR_E[0];

  assign md_stall = hilo_cls_d & (md_start | md_busy);
  assign stall_D  = resetn & (ld_stall | md_stall) & ~exc_flush;
  assign flush_E  = stall_D;

  assign md_done      = md_done_q;
  assign stall_cycles = stall_cycles_q;

  always_comb begin
    cnt_d = cnt_q;
    case (state)
      StIdle: begin
        if (md_start) begin
          cnt_d = IR_E[1] ? DivCnt : MultCnt;
        end
      end
      default: begin
        // A flush aborts the operation outright.
        cnt_d = exc_flush ? 5'd0 : cnt_q - 5'd1;
      end
    endcase
  end

  // Registered so that the pulse lands in the first idle cycle.
  assign md_done_d      = (cnt_q == 5'd1) & ~exc_flush;
  assign stall_cycles_d = stall_cycles_q + {31'd0, stall_D};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q          <= 5'd0;
      md_done_q      <= 1'b0;
      stall_cycles_q <= 32'd0;
    end else begin
      cnt_q          <= cnt_d;
      md_done_q      <= md_done_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Immediate and rd fields play no part in hazard detection.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{IR_D[15:6], IR_E[25:21], IR_E[15:6]};

endmodule

// File: tb/tb_md_stall_ctrl.sv
module tb_md_stall_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  localparam logic [31:0] NOP = 32'h0;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] ir_d, ir_e;
  logic [1:0]  use_bus;
  logic        mem_read, exc_flush;
  logic        stall_d, flush_e, md_start, md_is_div, md_signed, md_busy, md_done;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  md_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .IR_D        (ir_d),
    .IR_E        (ir_e),
    .use_bus_D   (use_bus),
    .mem_read_E  (mem_read),
    .exc_flush   (exc_flush),
    .stall_D     (stall_d),
    .flush_E     (flush_e),
    .md_start    (md_start),
    .md_is_div   (md_is_div),
    .md_signed   (md_signed),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .stall_cycles(stall_cycles)
  );

  typedef struct {
    bit        stall;
    bit        start;
    bit        is_div;
    bit        sgn;
    bit        chk_md;
    bit        busy;
    bit        done;
    bit [31:0] cnt;
    bit        chk_reg;
    bit        e_start;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int total = 0;
  int bad   = 0;

  // Reference model: busy window and done cycle expressed as absolute cycle numbers.
  longint    cyc       = 0;
  longint    busy_last = -1;
  longint    done_cyc  = -1;
  bit [31:0] m_cnt     = 0;

  function automatic bit is_start(input logic [31:0] ir);
    return (ir[31:26] == 6'd0) &&
           (ir[5:0] inside {6'b011000, 6'b011001, 6'b011010, 6'b011011});
  endfunction

  function automatic bit is_hilo(input logic [31:0] ir);
    return is_start(ir) || ((ir[31:26] == 6'd0) &&
           (ir[5:0] inside {6'b010000, 6'b010001, 6'b010010, 6'b010011}));
  endfunction

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input logic [5:0] f);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
  endfunction

  function automatic logic [31:0] lw(input int rt);
    return {6'b100011, 5'd29, 5'(rt), 16'h0010};
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [5:0] f;
    logic [5:0] op;
    case ($urandom_range(0, 7))
      0:       f = 6'b011000;
      1:       f = 6'b011001;
      2:       f = 6'b011010;
      3:       f = 6'b011011;
      4:       f = 6'b010000 + 6'($urandom_range(0, 3));
      default: f = 6'($urandom);
    endcase
    op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'd0, f};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle, push the expected response, advance the model, wait for next cycle.
  task automatic step(input logic [31:0] d, input logic [31:0] e, input logic [1:0] ub,
                      input logic mr, input logic fl, input logic rn);
    exp_t x;
    bit   busy, start, ld, stall;
    int   n;
    ir_d = d; ir_e = e; use_bus = ub; mem_read = mr; exc_flush = fl; resetn = rn;
    busy  = (cyc <= busy_last);
    start = rn && is_start(e) && !busy && !fl;
    ld    = mr && (e[20:16] != 5'd0) &&
            ((ub[1] && d[25:21] == e[20:16]) || (ub[0] && d[20:16] == e[20:16]));
    stall = rn && !fl && (ld || (is_hilo(d) && (start || busy)));
    x.stall   = stall;
    x.start   = start;
    x.is_div  = start && e[1];
    x.sgn     = start && !e[0];
    x.chk_md  = start || !rn;
    x.busy    = busy;
    x.done    = (cyc == done_cyc);
    x.cnt     = m_cnt;
    x.chk_reg = (cyc > 0);
    x.e_start = is_start(e) && !fl && rn;
    sb.push_back(x);
    if (!rn) begin
      m_cnt = 0; busy_last = -1; done_cyc = -1;
    end else begin
      m_cnt = m_cnt + 32'(stall);
      if (fl && busy) begin
        busy_last = cyc; done_cyc = -1;
      end
      if (start) begin
        n = e[1] ? DIV_N : MULT_N;
        busy_last = cyc + n;
        done_cyc  = cyc + n + 1;
      end
    end
    cyc++;
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_x = sb.pop_front();
      chk("stall_D", stall_d, mon_x.stall);
      chk("flush_E", flush_e, mon_x.stall);
      chk("md_start", md_start, mon_x.start);
      if (mon_x.chk_md) begin
        chk("md_is_div", md_is_div, mon_x.is_div);
        chk("md_signed", md_signed, mon_x.sgn);
      end
      if (mon_x.chk_reg) begin
        chk("md_busy", md_busy, mon_x.busy);
        chk("md_done", md_done, mon_x.done);
        chk("stall_cycles", stall_cycles, mon_x.cnt);
        if (mon_x.e_start) chk("no_start_while_busy", md_busy, 0);
      end
    end
  end

  initial begin
    resetn = 0; ir_d = NOP; ir_e = NOP; use_bus = 0; mem_read = 0; exc_flush = 0;
    @(posedge clk);
    #2;
    repeat (3) step(NOP, NOP, 2'b00, 0, 0, 0);
    step(NOP, NOP, 2'b00, 0, 0, 1);

    // Load-use on $5, then the bubble cycle, then rt = $0.
    step(rtype(5, 2, 3, 6'b100001), lw(5), 2'b11, 1, 0, 1);
    step(rtype(5, 2, 3, 6'b100001), NOP, 2'b11, 0, 0, 1);
    step(rtype(0, 2, 3, 6'b100001), lw(0), 2'b11, 1, 0, 1);

    // mult with mflo waiting in D.
    step(rtype(0, 0, 7, 6'b010010), rtype(4, 6, 0, 6'b011000), 2'b00, 0, 0, 1);
    repeat (6) step(rtype(0, 0, 7, 6'b010010), NOP, 2'b00, 0, 0, 1);
    step(NOP, rtype(0, 0, 7, 6'b010010), 2'b00, 0, 0, 1);

    // divu with an independent addu in D.
    step(rtype(8, 9, 10, 6'b100001), rtype(4, 6, 0, 6'b011011), 2'b11, 0, 0, 1);
    repeat (11) step(rtype(8, 9, 10, 6'b100001), NOP, 2'b11, 0, 0, 1);

    // Abort a divu at cnt = 4 with a mult sitting in E.
    step(NOP, rtype(4, 6, 0, 6'b011011), 2'b00, 0, 0, 1);
    repeat (6) step(rtype(0, 0, 7, 6'b010010), NOP, 2'b00, 0, 0, 1);
    step(rtype(0, 0, 7, 6'b010010), rtype(4, 6, 0, 6'b011000), 2'b00, 0, 1, 1);
    repeat (12) step(NOP, NOP, 2'b00, 0, 0, 1);

    // Reset mid-divide at cnt = 7.
    step(NOP, rtype(4, 6, 0, 6'b011010), 2'b00, 0, 0, 1);
    repeat (3) step(rtype(0, 0, 7, 6'b010010), NOP, 2'b00, 0, 0, 1);
    step(rtype(0, 0, 7, 6'b010010), NOP, 2'b00, 0, 0, 0);
    repeat (12) step(NOP, NOP, 2'b00, 0, 0, 1);

    // Counter wrap.
    force dut.stall_cycles_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cycles_q;
    m_cnt = 32'hFFFF_FFFF;
    step(rtype(5, 2, 3, 6'b100001), lw(5), 2'b11, 1, 0, 1);
    step(NOP, NOP, 2'b00, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] d, e;
      logic        fl, rn;
      d  = rand_ir();
      e  = ($urandom_range(0, 3) == 0) ? lw($urandom_range(0, 3)) : rand_ir();
      fl = ($urandom_range(0, 15) == 0);
      rn = ($urandom_range(0, 63) != 0);
      // A start in E while busy cannot happen in the real pipeline.
      if (is_start(e) && !fl && (cyc <= busy_last)) e = rtype(1, 2, 3, 6'b100001);
      step(d, e, 2'($urandom), 1'($urandom), fl, rn);
    end

    repeat (2) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_stall_ctrl.md
# md_stall_ctrl

Pipeline hazard controller for the five-stage MIPS core. It resolves the hazards that operand forwarding cannot cover: load-use dependences and conflicts on the multi-cycle multiply/divide unit (MDU). It sequences the MDU with a busy counter, and drives the D-stage stall, the E-stage bubble and the MDU start strobe. It also keeps a stall-cycle performance counter. It sits beside the E-stage forwarding logic, between the decoder's IR_D/IR_E pipeline registers and the MDU.

## Interface
- MULT_CYCLES, 5: MDU latency in cycles for mult/multu (legal range 1–31).
- DIV_CYCLES, 10: MDU latency in cycles for div/divu (legal range 1–31).

- clk  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- IR_D  in  32  instruction in D stage.
- IR_E  in  32  instruction in E stage.
- use_bus_D  in  2  [1] = the D instruction reads rs in D/E; [0] = the D instruction reads rt in D/E.
- mem_read_E  in  1  the E instruction is a load writing IR_E[20:16].
- exc_flush  in  1  exception/eret flush of the pipeline this cycle.
- stall_D  out  1  freeze the PC and the IF/ID register.
- flush_E  out  1  load a bubble into the ID/EX register.
- md_start  out  1  one-cycle MDU start strobe.
- md_is_div  out  1  valid with md_start: 1 = div/divu, 0 = mult/multu.
- md_signed  out  1  valid with md_start: 1 = mult/div, 0 = multu/divu.
- md_busy  out  1  the MDU is computing.
- md_done  out  1  one-cycle pulse when a result is written to HI/LO.
- stall_cycles  out  32  count of cycles with stall_D = 1; wraps modulo 2^32.

## Operation
- Decode applies only when the opcode is 000000. Start class is mult 011000, multu 011001, div 011010 and divu 011011. HI/LO class is the start class plus mfhi 010000, mthi 010001, mflo 010010 and mtlo 010011.
- Load-use stall (ld_stall) is asserted when all of the following hold:
  - mem_read_E = 1;
  - rtE = IR_E[20:16] is not 0;
  - either use_bus_D[1] = 1 and IR_D[25:21] = rtE, or use_bus_D[0] = 1 and IR_D[20:16] = rtE.
- md_start = (IR_E is start class) & ~md_busy & ~exc_flush. md_is_div is taken from funct[1], and md_signed = ~funct[0].
- md_stall = (IR_D is HI/LO class) & (md_start | md_busy).
- stall_D = (ld_stall | md_stall) & ~exc_flush, and flush_E = stall_D. exc_flush overrides every stall, because the pipeline flush logic owns that cycle.
- MDU state is a 5-bit counter cnt; md_busy = (cnt != 0). There are two states: IDLE (cnt = 0) and BUSY (cnt != 0).
  - IDLE → BUSY on md_start: cnt is loaded with MULT_CYCLES or DIV_CYCLES.
  - In BUSY, cnt decrements by 1 each cycle.
  - BUSY → IDLE when cnt reaches 0. md_done is a registered pulse set in the cycle when cnt = 1 and there is no exc_flush, so it is high exactly in the first IDLE cycle.
- exc_flush in BUSY aborts the operation: cnt is cleared to 0 on the next edge, md_done is not pulsed, and HI/LO keep their old value (enforced by the MDU on abort).
- A start-class instruction in E while md_busy = 1 cannot occur, because md_stall holds it in D. The bench asserts this never happens. If it does happen, md_start stays 0 and the instruction is ignored.
- stall_cycles increments by 1 on every edge where stall_D = 1 and resetn = 1, and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (resetn = 0 at an edge) sets cnt = 0, md_done = 0 and stall_cycles = 0. While resetn = 0, stall_D, flush_E, md_start, md_is_div and md_signed are forced to 0, and md_busy reads 0 from the cycle after the reset edge. Reset in mid-operation discards the operation with no md_done.
- stall_D, flush_E, md_start, md_is_div and md_signed are combinational, with zero-cycle latency from the IR and control inputs.
- MDU sequence when md_start is high in cycle t with latency N:
  - md_busy is high in cycles t+1 … t+N;
  - md_done is high in cycle t+N+1, and md_busy is low in that cycle;
  - a HI/LO-class instruction waiting in D stalls in cycles t … t+N and advances in cycle t+N+1.
- A load-use stall lasts exactly 1 cycle, because the load moves on to M. ld_stall and md_stall in the same cycle give a single stall_D with no double counting.

## Test plan
- Load-use: IR_E = lw $5 with mem_read_E = 1, IR_D = addu $3,$5,$2 with use_bus_D = 2'b11 → stall_D = flush_E = 1 for exactly 1 cycle, and stall_cycles increments by 1. Repeat with rt = $0 → no stall.
- Multiply sequencing: IR_E = mult (funct 011000), IR_D = mflo, default parameters → md_start = 1 and md_signed = 1 in cycle t, md_busy high in t+1…t+5, md_done high in t+6, stall_D high in t…t+5, and stall_cycles = 6.
- Divide: IR_E = divu → md_is_div = 1, md_signed = 0, md_busy high for 10 cycles, md_done in t+11. An independent addu in D during the busy period → no stall.
- Abort: during divu with cnt = 4, pulse exc_flush → stall_D = 0 in that cycle, md_busy = 0 on the next cycle, md_done is never asserted, and md_start = 0 even if IR_E is mult.
- Reset mid-operation: resetn = 0 while cnt = 7 → on the next cycle md_busy = 0 and stall_cycles = 0, and md_done stays 0.
- Counter wrap: preload stall_cycles to 0xFFFFFFFF via hierarchy force, then produce one stall cycle → stall_cycles = 0x00000000.
